// File: rtl/unidad_control_microprog_pkg.sv
// Shared state encoding, ALU field codes and width helpers for the microprogrammed control unit.
package uc_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_EXEC = 2'd1,
      ST_DONE = 2'd2
   } uc_state_e;

   localparam logic [1:0] ALU_NONE = 2'b00;
   localparam logic [1:0] ALU_ADD  = 2'b01;
   localparam logic [1:0] ALU_SUB  = 2'b10;

   function automatic int sel_w(input int nreg);
      return $clog2(nreg + 32'sd2);
   endfunction

   function automatic int word_w(input int nreg);
      return 32'sd3 + 32'sd2 * sel_w(nreg);
   endfunction

   localparam int DEF_WORD_W = word_w(32'sd3);

   // A/B swap through AC, then C <- A + B; word = {last, alu, src, dst}, NREG=3 (T=3, AC=4).
   localparam logic [DEF_WORD_W-1:0] DEFAULT_PROG [16] = '{
      9'b0_00_000_100, 9'b0_00_001_000, 9'b0_00_011_001, 9'b0_00_000_011,
      9'b0_01_001_100, 9'b1_00_011_010, 9'b0_00_000_000, 9'b0_00_000_000,
      9'b0_00_000_000, 9'b0_00_000_000, 9'b0_00_000_000, 9'b0_00_000_000,
      9'b0_00_000_000, 9'b0_00_000_000, 9'b0_00_000_000, 9'b0_00_000_000
   };

endpackage

// File: rtl/unidad_control_microprog_if.sv
// Start/stall/program inputs and decoded datapath controls of the microprogrammed control unit.
interface unidad_control_microprog_if #(
   parameter int NREG  = 3,
   parameter int DEPTH = 16
) ();
   localparam int AW     = $clog2(DEPTH);
   localparam int WORD_W = uc_pkg::word_w(NREG);

   logic              xs;
   logic [AW-1:0]     entry;
   logic              hold;
   logic              prog_we;
   logic [AW-1:0]     prog_addr;
   logic [WORD_W-1:0] prog_data;
   logic [NREG-1:0]   W;
   logic [NREG-1:0]   Rd;
   logic              Wt;
   logic              Wac;
   logic              Rac;
   logic              S;
   logic              R;
   logic              busy;
   logic              fin;
   logic              err;

   modport master (
      output xs, entry, hold, prog_we, prog_addr, prog_data,
      input  W, Rd, Wt, Wac, Rac, S, R, busy, fin, err
   );

   modport slave (
      input  xs, entry, hold, prog_we, prog_addr, prog_data,
      output W, Rd, Wt, Wac, Rac, S, R, busy, fin, err
   );
endinterface

// File: rtl/unidad_control_microprog_ucode_mem.sv
// Microcode store: flop array, synchronous write, asynchronous read, contents survive reset.
module ucode_mem #(
   parameter int DEPTH  = 16,
   parameter int WORD_W = 9
) (
   input  logic                     clk,
   input  logic                     we,
   input  logic [$clog2(DEPTH)-1:0] waddr,
   input  logic [WORD_W-1:0]        wdata,
   input  logic [$clog2(DEPTH)-1:0] raddr,
   output logic [WORD_W-1:0]        rdata
);
   logic [WORD_W-1:0] mem_r [DEPTH];

   // Write port.
   always_ff @(posedge clk) begin
      if (we) begin
         mem_r[waddr] <= wdata;
      end
   end

   assign rdata = mem_r[raddr];
endmodule

// File: rtl/unidad_control_microprog.sv
// Microprogrammed sequencer for the shared-bus register datapath: steps through microcode
// from an entry address and decodes each word into one-hot read/write and ALU controls.
module unidad_control_microprog
   import uc_pkg::*;
#(
   parameter int NREG  = 3,
   parameter int DEPTH = 16
) (
   input  logic                     clk,
   input  logic                     reset_n,
   unidad_control_microprog_if.slave bus
);
   localparam int SEL_W  = sel_w(NREG);
   localparam int WORD_W = word_w(NREG);
   localparam int AW     = $clog2(DEPTH);

   localparam logic [SEL_W-1:0] SEL_T   = SEL_W'(NREG);
   localparam logic [SEL_W-1:0] SEL_AC  = SEL_W'(NREG + 32'sd1);
   localparam logic [AW-1:0]    PC_LAST = AW'(DEPTH - 32'sd1);
   localparam logic [AW-1:0]    PC_ONE  = AW'(32'sd1);

   uc_state_e         state_r;
   uc_state_e         state_nxt_s;
   logic [AW-1:0]     pc_r;
   logic [AW-1:0]     pc_nxt_s;
   logic              err_r;
   logic              err_nxt_s;
   logic [WORD_W-1:0] word_s;
   logic              last_s;
   logic [1:0]        alu_s;
   logic [SEL_W-1:0]  src_s;
   logic [SEL_W-1:0]  dst_s;
   logic              exec_s;
   logic              mem_we_s;
   logic [NREG-1:0]   w_s;
   logic [NREG-1:0]   rd_s;
   logic              wt_s;
   logic              wac_s;
   logic              rac_s;
   logic              s_s;
   logic              r_s;
   logic              busy_s;
   logic              fin_s;
   logic              err_s;

   // Programming is locked out for the whole run so a run never sees a half-edited program.
   assign mem_we_s = bus.prog_we & (state_r == ST_IDLE);

   ucode_mem #(
      .DEPTH  (DEPTH),
      .WORD_W (WORD_W)
   ) u_ucode_mem (
      .clk   (clk),
      .we    (mem_we_s),
      .waddr (bus.prog_addr),
      .wdata (bus.prog_data),
      .raddr (pc_r),
      .rdata (word_s)
   );

   assign {last_s, alu_s, src_s, dst_s} = word_s;
   assign exec_s = (state_r == ST_EXEC) & ~bus.hold;

   // State, program counter and end-of-run error flag.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_r <= ST_IDLE;
         pc_r    <= {AW{1'b0}};
         err_r   <= 1'b0;
      end else begin
         state_r <= state_nxt_s;
         pc_r    <= pc_nxt_s;
         err_r   <= err_nxt_s;
      end
   end

   // Sequencing: start, stall, last-bit termination and end-of-memory termination.
   always_comb begin
      state_nxt_s = state_r;
      pc_nxt_s    = pc_r;
      err_nxt_s   = err_r;
      case (state_r)
         ST_IDLE: begin
            err_nxt_s = 1'b0;
            if (bus.xs) begin
               state_nxt_s = ST_EXEC;
               pc_nxt_s    = bus.entry;
            end else begin
               state_nxt_s = ST_IDLE;
            end
         end
         ST_EXEC: begin
            if (bus.hold) begin
               state_nxt_s = ST_EXEC;
            end else if (last_s) begin
               state_nxt_s = ST_DONE;
               err_nxt_s   = 1'b0;
            end else if (pc_r == PC_LAST) begin
               state_nxt_s = ST_DONE;
               err_nxt_s   = 1'b1;
            end else begin
               pc_nxt_s = pc_r + PC_ONE;
            end
         end
         ST_DONE: begin
            state_nxt_s = ST_IDLE;
         end
         default: begin
            state_nxt_s = ST_IDLE;
            pc_nxt_s    = {AW{1'b0}};
            err_nxt_s   = 1'b0;
         end
      endcase
   end

   // Word decode; ALU ops only make sense when the result lands in AC.
   always_comb begin
      w_s    = {NREG{1'b0}};
      rd_s   = {NREG{1'b0}};
      wt_s   = 1'b0;
      wac_s  = 1'b0;
      rac_s  = 1'b0;
      s_s    = 1'b0;
      r_s    = 1'b0;
      busy_s = (state_r != ST_IDLE);
      fin_s  = (state_r == ST_DONE);
      err_s  = fin_s & err_r;
      if (exec_s) begin
         for (int i = 32'sd0; i < NREG; i++) begin
            rd_s[i] = (src_s == SEL_W'(i));
            w_s[i]  = (dst_s == SEL_W'(i));
         end
         rac_s = (src_s == SEL_T);
         wt_s  = (dst_s == SEL_T);
         wac_s = (dst_s == SEL_AC);
         s_s   = wac_s & (alu_s == ALU_ADD);
         r_s   = wac_s & (alu_s == ALU_SUB);
      end else begin
         w_s  = {NREG{1'b0}};
         rd_s = {NREG{1'b0}};
      end
   end

   assign bus.W    = w_s;
   assign bus.Rd   = rd_s;
   assign bus.Wt   = wt_s;
   assign bus.Wac  = wac_s;
   assign bus.Rac  = rac_s;
   assign bus.S    = s_s;
   assign bus.R    = r_s;
   assign bus.busy = busy_s;
   assign bus.fin  = fin_s;
   assign bus.err  = err_s;
endmodule

// File: tb/tb_unidad_control_microprog.sv
// Scoreboarded bench: per-cycle stimulus and expected control vectors are queued, then replayed and compared.
module tb_unidad_control_microprog;
   import uc_pkg::*;

   localparam int NREG  = 3;
   localparam int DEPTH = 16;

   typedef struct packed {
      logic [2:0] w;
      logic [2:0] rd;
      logic       wt, wac, rac, s, r, busy, fin, err;
   } obs_t;

   typedef struct {
      logic       xs;
      logic [3:0] entry;
      logic       hold;
      logic       pwe;
      logic [3:0] paddr;
      logic [8:0] pdata;
      obs_t       exp;
   } item_t;

   // {W, Rd, {Wt,Wac,Rac,S,R}, {busy,fin,err}}
   localparam obs_t IDLE_O = {3'b000, 3'b000, 5'b00000, 3'b000};
   localparam obs_t BUSY_O = {3'b000, 3'b000, 5'b00000, 3'b100};
   localparam obs_t FIN0_O = {3'b000, 3'b000, 5'b00000, 3'b110};
   localparam obs_t FIN1_O = {3'b000, 3'b000, 5'b00000, 3'b111};
   localparam obs_t B1     = {3'b000, 3'b001, 5'b10000, 3'b100};
   localparam obs_t B2     = {3'b000, 3'b001, 5'b01010, 3'b100};
   localparam obs_t B3     = {3'b100, 3'b000, 5'b00100, 3'b100};

   logic  clk;
   logic  reset_n;
   int    n_cmp;
   int    n_mis;
   item_t q[$];

   unidad_control_microprog_if #(.NREG(NREG), .DEPTH(DEPTH)) bus ();

   unidad_control_microprog #(.NREG(NREG), .DEPTH(DEPTH)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic obs_t sample();
      return {bus.W, bus.Rd, bus.Wt, bus.Wac, bus.Rac, bus.S, bus.R, bus.busy, bus.fin, bus.err};
   endfunction

   task automatic push(input logic xs, input logic [3:0] entry, input logic hold, input logic pwe,
                       input logic [3:0] pa, input logic [8:0] pd, input obs_t e);
      item_t it;
      it.xs = xs; it.entry = entry; it.hold = hold; it.pwe = pwe;
      it.paddr = pa; it.pdata = pd; it.exp = e;
      q.push_back(it);
   endtask

   task automatic push_e(input obs_t e);
      push(1'b0, 4'd0, 1'b0, 1'b0, 4'd0, 9'd0, e);
   endtask

   task automatic push_x(input logic [3:0] entry);
      push(1'b1, entry, 1'b0, 1'b0, 4'd0, 9'd0, IDLE_O);
   endtask

   task automatic apply(input item_t it);
      bus.xs = it.xs; bus.entry = it.entry; bus.hold = it.hold;
      bus.prog_we = it.pwe; bus.prog_addr = it.paddr; bus.prog_data = it.pdata;
   endtask

   task automatic load(input logic [3:0] addr, input logic [8:0] data);
      bus.prog_addr = addr; bus.prog_data = data; bus.prog_we = 1'b1;
      @(posedge clk); #1;
      bus.prog_we = 1'b0;
   endtask

   task automatic load_p1();
      load(4'd0, 9'b0_00_000_011);
      load(4'd1, 9'b0_01_000_100);
      load(4'd2, 9'b1_00_011_010);
   endtask

   task automatic test_reset();
      obs_t o;
      repeat (2) @(negedge clk);
      o = sample(); n_cmp++;
      if (o !== IDLE_O) begin n_mis++; $display("FAIL reset: got %b required %b", o, IDLE_O); end
      reset_n = 1'b1;
      @(posedge clk); #1;
      @(negedge clk);
      o = sample(); n_cmp++;
      if (o !== IDLE_O) begin n_mis++; $display("FAIL reset_release: got %b required %b", o, IDLE_O); end
      @(posedge clk); #1;
   endtask

   task automatic test_basic();
      item_t it; obs_t o; int c;
      load_p1();
      push_x(4'd0); push_e(B1); push_e(B2); push_e(B3); push_e(FIN0_O); push_e(IDLE_O);
      c = 0;
      while (q.size() != 0) begin
         it = q.pop_front(); apply(it);
         @(negedge clk); o = sample(); n_cmp++;
         if (o !== it.exp) begin n_mis++; $display("FAIL basic c%0d: got %b required %b", c, o, it.exp); end
         c++; @(posedge clk); #1;
      end
   endtask

   task automatic test_hold();
      item_t it; obs_t o; int c;
      push_x(4'd0); push_e(B1);
      push(1'b0, 4'd0, 1'b1, 1'b0, 4'd0, 9'd0, BUSY_O);
      push_e(B2); push_e(B3); push_e(FIN0_O); push_e(IDLE_O);
      c = 0;
      while (q.size() != 0) begin
         it = q.pop_front(); apply(it);
         @(negedge clk); o = sample(); n_cmp++;
         if (o !== it.exp) begin n_mis++; $display("FAIL hold c%0d: got %b required %b", c, o, it.exp); end
         c++; @(posedge clk); #1;
      end
   endtask

   task automatic test_busy_write();
      item_t it; obs_t o; int c;
      push_x(4'd0);
      push(1'b0, 4'd0, 1'b0, 1'b1, 4'd0, 9'b1_00_001_000, B1);
      push(1'b0, 4'd0, 1'b0, 1'b1, 4'd0, 9'b1_00_001_000, B2);
      push(1'b0, 4'd0, 1'b0, 1'b1, 4'd0, 9'b1_00_001_000, B3);
      push(1'b0, 4'd0, 1'b0, 1'b1, 4'd0, 9'b1_00_001_000, FIN0_O);
      push_e(IDLE_O);
      push_x(4'd0); push_e(B1); push_e(B2); push_e(B3); push_e(FIN0_O); push_e(IDLE_O);
      c = 0;
      while (q.size() != 0) begin
         it = q.pop_front(); apply(it);
         @(negedge clk); o = sample(); n_cmp++;
         if (o !== it.exp) begin n_mis++; $display("FAIL busy_write c%0d: got %b required %b", c, o, it.exp); end
         c++; @(posedge clk); #1;
      end
   endtask

   task automatic test_back_to_back();
      item_t it; obs_t o; int c;
      push(1'b1, 4'd0, 1'b0, 1'b0, 4'd0, 9'd0, IDLE_O);
      push(1'b1, 4'd0, 1'b0, 1'b0, 4'd0, 9'd0, B1);
      push(1'b1, 4'd5, 1'b0, 1'b0, 4'd0, 9'd0, B2);
      push(1'b1, 4'd0, 1'b0, 1'b0, 4'd0, 9'd0, B3);
      push(1'b1, 4'd0, 1'b0, 1'b0, 4'd0, 9'd0, FIN0_O);
      push(1'b1, 4'd0, 1'b0, 1'b1, 4'd2, 9'b1_00_011_001, IDLE_O);
      push_e(B1); push_e(B2);
      push_e({3'b010, 3'b000, 5'b00100, 3'b100});
      push_e(FIN0_O); push_e(IDLE_O);
      c = 0;
      while (q.size() != 0) begin
         it = q.pop_front(); apply(it);
         @(negedge clk); o = sample(); n_cmp++;
         if (o !== it.exp) begin n_mis++; $display("FAIL back_to_back c%0d: got %b required %b", c, o, it.exp); end
         c++; @(posedge clk); #1;
      end
   endtask

   task automatic test_illegal_fields();
      item_t it; obs_t o; int c;
      load(4'd0, 9'b0_11_111_111);
      load(4'd1, 9'b0_01_000_001);
      load(4'd2, 9'b0_10_100_101);
      load(4'd3, 9'b1_10_001_100);
      push_x(4'd0);
      push_e(BUSY_O);
      push_e({3'b010, 3'b001, 5'b00000, 3'b100});
      push_e(BUSY_O);
      push_e({3'b000, 3'b010, 5'b01001, 3'b100});
      push_e(FIN0_O); push_e(IDLE_O);
      c = 0;
      while (q.size() != 0) begin
         it = q.pop_front(); apply(it);
         @(negedge clk); o = sample(); n_cmp++;
         if (o !== it.exp) begin n_mis++; $display("FAIL illegal c%0d: got %b required %b", c, o, it.exp); end
         c++; @(posedge clk); #1;
      end
   endtask

   task automatic test_wrap();
      item_t it; obs_t o; int c;
      load(4'd14, 9'b0_00_000_011);
      load(4'd15, 9'b0_00_001_100);
      push_x(4'd14);
      push_e({3'b000, 3'b001, 5'b10000, 3'b100});
      push_e({3'b000, 3'b010, 5'b01000, 3'b100});
      push_e(FIN1_O); push_e(IDLE_O);
      c = 0;
      while (q.size() != 0) begin
         it = q.pop_front(); apply(it);
         @(negedge clk); o = sample(); n_cmp++;
         if (o !== it.exp) begin n_mis++; $display("FAIL wrap c%0d: got %b required %b", c, o, it.exp); end
         c++; @(posedge clk); #1;
      end
   endtask

   task automatic test_reset_mid_run();
      item_t it; obs_t o; int c;
      load_p1();
      push_x(4'd0); push_e(B1);
      while (q.size() != 0) begin
         it = q.pop_front(); apply(it);
         @(posedge clk); #1;
      end
      reset_n = 1'b0; #1;
      o = sample(); n_cmp++;
      if (o !== IDLE_O) begin n_mis++; $display("FAIL reset_async: got %b required %b", o, IDLE_O); end
      for (int k = 0; k < 3; k++) begin
         @(negedge clk); o = sample(); n_cmp++;
         if (o !== IDLE_O) begin n_mis++; $display("FAIL reset_hold c%0d: got %b required %b", k, o, IDLE_O); end
      end
      reset_n = 1'b1;
      @(posedge clk); #1;
      push_x(4'd0); push_e(B1); push_e(B2); push_e(B3); push_e(FIN0_O); push_e(IDLE_O);
      c = 0;
      while (q.size() != 0) begin
         it = q.pop_front(); apply(it);
         @(negedge clk); o = sample(); n_cmp++;
         if (o !== it.exp) begin n_mis++; $display("FAIL after_reset c%0d: got %b required %b", c, o, it.exp); end
         c++; @(posedge clk); #1;
      end
   endtask

   task automatic test_default_prog();
      item_t it; obs_t o; int c;
      for (int a = 0; a < DEPTH; a++) begin
         load(4'(a), DEFAULT_PROG[a]);
      end
      push_x(4'd0);
      push_e({3'b000, 3'b001, 5'b01000, 3'b100});
      push_e({3'b001, 3'b010, 5'b00000, 3'b100});
      push_e({3'b010, 3'b000, 5'b00100, 3'b100});
      push_e({3'b000, 3'b001, 5'b10000, 3'b100});
      push_e({3'b000, 3'b010, 5'b01010, 3'b100});
      push_e({3'b100, 3'b000, 5'b00100, 3'b100});
      push_e(FIN0_O); push_e(IDLE_O);
      c = 0;
      while (q.size() != 0) begin
         it = q.pop_front(); apply(it);
         @(negedge clk); o = sample(); n_cmp++;
         if (o !== it.exp) begin n_mis++; $display("FAIL default_prog c%0d: got %b required %b", c, o, it.exp); end
         c++; @(posedge clk); #1;
      end
   endtask

   initial begin
      n_cmp = 0;
      n_mis = 0;
      reset_n = 1'b0;
      bus.xs = 1'b0; bus.entry = 4'd0; bus.hold = 1'b0;
      bus.prog_we = 1'b0; bus.prog_addr = 4'd0; bus.prog_data = 9'd0;
      test_reset();
      test_basic();
      test_hold();
      test_busy_write();
      test_back_to_back();
      test_illegal_fields();
      test_wrap();
      test_reset_mid_run();
      test_default_prog();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end
endmodule
